// File: rtl/ncl_pkg.sv
// ncl_pkg
// Shared definitions for the NCL tokenflow output channel and its clocked
// sink controller.
//   - default widths/depths used by the sink and the tokenflow instance
//   - sink sequencer state encoding
//   - channel field layout (req / ack / bundled data) shared with tokenflow
package ncl_pkg;

    localparam int NCL_W       = 26;
    localparam int NCL_SYNC    = 2;
    localparam int NCL_TO_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_HOLD_ACK = 2'd2,
        ST_DONE     = 2'd3
    } ncl_state_t;

    // Bundled-data channel as seen by tokenflow: data is valid while req=1
    // and ack=0.
    typedef struct packed {
        logic             req;
        logic             ack;
        logic [NCL_W-1:0] data;
    } ncl_chan_t;

endpackage

// File: rtl/ncl_req_sync.sv
// ncl_req_sync
// Multi-flop synchronizer for an asynchronous single-bit input. All stages
// reset to 0, so a request held high through reset is seen as a fresh rise
// once reset is released.
// Ports:
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input
//   q      out  synchronized output, SYNC clocks of latency
module ncl_req_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC-2:0], d};
        end
    end

    assign q = stage[SYNC-1];

endmodule

// File: rtl/ncl_sink_ctrl.sv
// ncl_sink_ctrl
// Clocked consumer for the NCL tokenflow output channel. Synchronizes the
// 4-phase request, drives the acknowledge, captures each bundled token and
// sequences bursts of a programmed length with an XOR fold, a token count
// and a handshake watchdog.
// Ports:
//   clk        in   single clock
//   rst_n      in   asynchronous active-low reset
//   start      in   launch a burst (honoured only when idle)
//   burst_len  in   tokens per burst, latched on start; 0 = free-run
//   abort      in   level; ends the burst at the next safe point
//   req_in     in   asynchronous 4-phase request
//   data_in    in   bundled token data
//   ack_out    out  4-phase acknowledge (registered, glitch-free)
//   last_data  out  most recently captured token
//   xor_acc    out  XOR of all tokens captured this burst
//   tok_cnt    out  tokens captured this burst, mod 256
//   busy       out  sequencer active
//   done       out  one-cycle pulse at normal burst completion
//   timeout    out  sticky watchdog flag, cleared by an accepted start
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ack low, waiting for start
// WAIT_REQ | ack low, waiting for synchronized req to rise (capture)
// HOLD_ACK | ack high, waiting for synchronized req to fall
// DONE     | burst completed normally, done pulses for one cycle
module ncl_sink_ctrl
    import ncl_pkg::*;
#(
    parameter int W       = NCL_W,
    parameter int SYNC    = NCL_SYNC,
    parameter int TO_BITS = NCL_TO_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [7:0]   burst_len,
    input  logic         abort,
    input  logic         req_in,
    input  logic [W-1:0] data_in,
    output logic         ack_out,
    output logic [W-1:0] last_data,
    output logic [W-1:0] xor_acc,
    output logic [7:0]   tok_cnt,
    output logic         busy,
    output logic         done,
    output logic         timeout
);

    ncl_state_t state, state_nxt;

    logic               req_s;
    logic [7:0]         len_q;
    logic [7:0]         tok_cnt_q;
    logic [W-1:0]       last_q;
    logic [W-1:0]       xor_q;
    logic               ack_q;
    logic               timeout_q;
    logic [TO_BITS-1:0] wd_cnt;
    logic               wd_exp;
    logic               wd_fire;
    logic               accept;
    logic               capture;

    ncl_req_sync #(.SYNC(SYNC)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (req_in),
        .q     (req_s)
    );

    // The watchdog holds the number of cycles still allowed in the current
    // state; the edge that would consume the last one is the expiry edge,
    // giving exactly 2^TO_BITS-1 cycles without a handshake edge.
    assign wd_exp  = (wd_cnt == TO_BITS'(1));
    assign accept  = (state == ST_IDLE) && start;
    assign capture = (state == ST_WAIT_REQ) && req_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wd_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT_REQ;
                end
            end
            ST_WAIT_REQ: begin
                if (req_s) begin
                    state_nxt = ST_HOLD_ACK;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (wd_exp) begin
                    state_nxt = ST_IDLE;
                    wd_fire   = 1'b1;
                end
            end
            ST_HOLD_ACK: begin
                // abort is only honoured once the return phase is seen, so
                // a handshake in flight is never cut short
                if (!req_s) begin
                    if (abort) begin
                        state_nxt = ST_IDLE;
                    end else if ((len_q != 8'd0) && (tok_cnt_q == len_q)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_WAIT_REQ;
                    end
                end else if (wd_exp) begin
                    state_nxt = ST_IDLE;
                    wd_fire   = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            len_q     <= 8'd0;
            tok_cnt_q <= 8'd0;
            last_q    <= '0;
            xor_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            // ack is a flop decoded from the next state so tokenflow never
            // sees a decode glitch
            ack_q <= (state_nxt == ST_HOLD_ACK);
            if (accept) begin
                len_q     <= burst_len;
                tok_cnt_q <= 8'd0;
                xor_q     <= '0;
                timeout_q <= 1'b0;
            end
            if (capture) begin
                last_q    <= data_in;
                xor_q     <= xor_q ^ data_in;
                tok_cnt_q <= tok_cnt_q + 8'd1;
            end
            if (wd_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '1;
        end else if (state_nxt != state) begin
            wd_cnt <= '1;
        end else if ((state == ST_WAIT_REQ) || (state == ST_HOLD_ACK)) begin
            wd_cnt <= wd_cnt - TO_BITS'(1);
        end
    end

    assign ack_out   = ack_q;
    assign last_data = last_q;
    assign xor_acc   = xor_q;
    assign tok_cnt   = tok_cnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_ncl_sink_ctrl.sv
module tb_ncl_sink_ctrl;

    localparam int W = 26;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   burst_len;
    logic         abort;
    logic         req_in;
    logic [W-1:0] data_in;
    logic         ack_out;
    logic [W-1:0] last_data;
    logic [W-1:0] xor_acc;
    logic [7:0]   tok_cnt;
    logic         busy;
    logic         done;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    ncl_sink_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .last_data (last_data),
        .xor_acc   (xor_acc),
        .tok_cnt   (tok_cnt),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [7:0]        len;
        logic [2:0][W-1:0] d;
        logic [7:0]        exp_tok;
        logic [W-1:0]      exp_last;
        logic [W-1:0]      exp_xor;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input logic [7:0] len, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] c,
                                input logic [7:0] tk, input logic [W-1:0] lst,
                                input logic [W-1:0] xr);
        vec_t v;
        v.len = len;
        v.d[0] = a;
        v.d[1] = b;
        v.d[2] = c;
        v.exp_tok = tk;
        v.exp_last = lst;
        v.exp_xor = xr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // start pulse issued from a negedge; returns on the negedge after the
    // accepting posedge
    task automatic pulse_start(input logic [7:0] len);
        start = 1'b1;
        burst_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    // one complete 4-phase token from the tokenflow side; ack must rise and
    // fall three edges after the corresponding req transition
    task automatic send_token(input logic [W-1:0] d);
        int n;
        data_in = d;
        req_in = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_out !== 1'b1 && n < 20);
        check("ack_rise_latency", n, 3);
        req_in = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack_out !== 1'b0 && n < 20);
        check("ack_fall_latency", n, 3);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int dc;
        logic [W-1:0] xr;
        logic [W-1:0] lst;

        vecs[0] = mk(8'd3, 26'd0, 26'd2, 26'd6, 8'd3, 26'd6, 26'd4);
        vecs[1] = mk(8'd1, 26'h3FFFFFF, 26'd0, 26'd0, 8'd1, 26'h3FFFFFF, 26'h3FFFFFF);
        vecs[2] = mk(8'd2, 26'd5, 26'd5, 26'd0, 8'd2, 26'd5, 26'd0);
        vecs[3] = mk(8'd3, 26'd1, 26'd2, 26'd4, 8'd3, 26'd4, 26'd7);
        vecs[4] = mk(8'd2, 26'h2AAAAAA, 26'h1555555, 26'd0, 8'd2, 26'h1555555, 26'h3FFFFFF);

        rst_n = 1'b0;
        start = 1'b0;
        burst_len = 8'd0;
        abort = 1'b0;
        req_in = 1'b1;
        data_in = 26'h1234567;

        // reset with req held high
        cycles(4);
        check("rst_ack", ack_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_tok", tok_cnt, 0);
        check("rst_last", last_data, 0);
        check("rst_xor", xor_acc, 0);
        rst_n = 1'b1;
        cycles(6);
        check("idle_ack_no_start", ack_out, 0);
        check("idle_busy_no_start", busy, 0);
        req_in = 1'b0;
        cycles(4);

        // table-driven bursts
        for (int v = 0; v < 5; v++) begin
            dc = done_cnt;
            pulse_start(vecs[v].len);
            check("burst_busy", busy, 1);
            check("burst_clr_tok", tok_cnt, 0);
            check("burst_clr_xor", xor_acc, 0);
            for (int t = 0; t < vecs[v].len; t++) begin
                cycles(1);
                send_token(vecs[v].d[t]);
                check("done_at_fall", done, (t == vecs[v].len - 1) ? 1 : 0);
            end
            cycles(1);
            check("burst_done_gone", done, 0);
            check("burst_busy_gone", busy, 0);
            check("burst_done_count", done_cnt - dc, 1);
            check("burst_tok", tok_cnt, vecs[v].exp_tok);
            check("burst_last", last_data, vecs[v].exp_last);
            check("burst_xor", xor_acc, vecs[v].exp_xor);
            cycles(2);
        end

        // abort while ack is held high: handshake must still complete
        dc = done_cnt;
        pulse_start(8'd5);
        cycles(1);
        data_in = 26'h00ABCDE;
        req_in = 1'b1;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (ack_out !== 1'b1 && n < 20);
            check("abort_ack_rise", n, 3);
        end
        abort = 1'b1;
        cycles(5);
        check("abort_ack_held", ack_out, 1);
        check("abort_busy_held", busy, 1);
        req_in = 1'b0;
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (ack_out !== 1'b0 && n < 20);
            check("abort_ack_fall", n, 3);
        end
        check("abort_idle", busy, 0);
        abort = 1'b0;
        cycles(2);
        check("abort_no_done", done_cnt - dc, 0);
        check("abort_tok", tok_cnt, 1);
        check("abort_last", last_data, 26'h00ABCDE);

        // watchdog expiry with req held low
        req_in = 1'b0;
        start = 1'b1;
        burst_len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        cycles(4094);
        check("wd_busy_before", busy, 1);
        check("wd_timeout_before", timeout, 0);
        cycles(1);
        check("wd_timeout", timeout, 1);
        check("wd_busy", busy, 0);
        check("wd_ack", ack_out, 0);
        cycles(3);
        check("wd_sticky", timeout, 1);
        pulse_start(8'd1);
        check("wd_cleared", timeout, 0);
        check("wd_restart_busy", busy, 1);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("wd_abort_idle", busy, 0);
        cycles(2);

        // free-run with wrap, ignored start mid-run, then abort
        dc = done_cnt;
        xr = '0;
        lst = '0;
        pulse_start(8'd0);
        for (int i = 1; i <= 300; i++) begin
            logic [W-1:0] d;
            d = W'(i * 37 + 5);
            xr = xr ^ d;
            lst = d;
            send_token(d);
            if (i == 100) begin
                pulse_start(8'd7);
                check("free_start_ignored", tok_cnt, 100);
            end
            if (i == 256) check("free_wrap_zero", tok_cnt, 0);
        end
        check("free_busy_running", busy, 1);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("free_idle", busy, 0);
        check("free_tok", tok_cnt, 44);
        check("free_xor", xor_acc, xr);
        check("free_last", last_data, lst);
        check("free_no_done", done_cnt - dc, 0);
        cycles(2);

        // req_s rises in the same cycle abort arrives in WAIT_REQ
        dc = done_cnt;
        pulse_start(8'd1);
        cycles(1);
        data_in = 26'h0F0F0F0;
        req_in = 1'b1;
        cycles(2);
        abort = 1'b1;
        check("coin_ack_low_yet", ack_out, 0);
        cycles(1);
        check("coin_ack", ack_out, 1);
        check("coin_tok", tok_cnt, 1);
        check("coin_last", last_data, 26'h0F0F0F0);
        req_in = 1'b0;
        cycles(2);
        check("coin_ack_hold", ack_out, 1);
        cycles(1);
        check("coin_ack_fall", ack_out, 0);
        check("coin_idle", busy, 0);
        abort = 1'b0;
        cycles(2);
        check("coin_no_done", done_cnt - dc, 0);

        // reset mid-handshake drops ack without a clock edge
        pulse_start(8'd2);
        cycles(1);
        req_in = 1'b1;
        cycles(3);
        check("midrst_ack_up", ack_out, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ack_async", ack_out, 0);
        check("midrst_busy_async", busy, 0);
        req_in = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ncl_sink_ctrl.md
# ncl_sink_ctrl

Clocked consumer and sequencer for the asynchronous NCL tokenflow output channel. It synchronizes the 4-phase `req`, drives `ack`, and captures each bundled data token. It runs bursts of a programmed token count and keeps a running XOR fold, a token count and a handshake watchdog. The block sits between the tokenflow instance and the clocked I/O logic of the tile, replacing the direct `ui_in[0]`-to-ack path.

## Interface
- `W`, 26: token data width; matches the tokenflow instance.
- `SYNC`, 2: synchronizer depth on `req_in`, ≥2.
- `TO_BITS`, 12: watchdog width; timeout fires after 2^TO_BITS−1 cycles without a handshake edge.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launches a burst; sampled only in IDLE.
- `burst_len`  in  8  tokens per burst, latched on `start`; 0 = free-run until `abort`.
- `abort`  in  1  level; ends the burst at the next safe point.
- `req_in`  in  1  asynchronous 4-phase request from tokenflow.
- `data_in`  in  W  bundled data; stable while `req_in`=1 and `ack_out`=0.
- `ack_out`  out  1  4-phase acknowledge to tokenflow.
- `last_data`  out  W  most recently captured token.
- `xor_acc`  out  W  XOR of all tokens captured this burst.
- `tok_cnt`  out  8  tokens captured this burst; mod 256.
- `busy`  out  1  high in WAIT_REQ, HOLD_ACK or DONE.
- `done`  out  1  one-cycle pulse at normal burst completion.
- `timeout`  out  1  sticky; cleared by an accepted `start`.

## Operation
- `req_s` = `req_in` through a SYNC-flop synchronizer. The FSM uses only `req_s`, never `req_in`.
- IDLE: `ack_out`=0. On `start`: clear `tok_cnt`, `xor_acc` and `timeout`, latch `burst_len`, then go to WAIT_REQ. `start` is ignored in every other state.
- WAIT_REQ:
  - If `req_s`=1: `last_data`<=`data_in`, `xor_acc`^=`data_in`, `tok_cnt`+=1, `ack_out`<=1, go to HOLD_ACK.
  - Else if `abort`: go to IDLE with no `done`.
- HOLD_ACK: wait for `req_s`=0, then `ack_out`<=0.
  - If `abort`: go to IDLE.
  - Else if `burst_len`≠0 and `tok_cnt`==`burst_len`: go to DONE.
  - Otherwise go to WAIT_REQ.
  - `abort` never truncates a handshake in progress.
- DONE: `done`=1 for this cycle only, then go to IDLE.
- Watchdog:
  - The counter clears on every state change and counts only in WAIT_REQ and HOLD_ACK.
  - On saturation: `timeout`<=1, `ack_out`<=0, go to IDLE, no `done`. Tokenflow must then be reset externally.
- Priority when events coincide: `req_s` edge over `abort`, and `abort` over watchdog.
- `tok_cnt` wraps 255→0 in free-run mode. The 8-bit comparison is against the latched length only.

## Timing
- Reset (async assert, synchronous-safe deassert is the integrator's job): all state in IDLE. `ack_out`, `last_data`, `xor_acc`, `tok_cnt`, `busy`, `done`, `timeout` and the synchronizer flops all reset to 0.
- Forward latency, SYNC=2: `req_in` rises before edge k, `ack_out` rises after edge k+2. Data is captured at that same edge.
- Return latency: `req_in` falls before edge j, `ack_out` falls after edge j+2.
- A full 4-phase token costs at least 2·(SYNC+1) cycles plus upstream delay.
- `done` is asserted in the cycle after the final `ack_out` fall. `busy` drops one cycle later.
- `rst_n` asserted mid-handshake forces `ack_out`=0 immediately. The upstream channel must be reset together with this block.

## Structure
- Shared package `ncl_pkg` holds:
  - the state enum IDLE/WAIT_REQ/HOLD_ACK/DONE;
  - default constants for W, SYNC and TO_BITS;
  - the `chan` req/ack/data field layout shared with tokenflow.
- Sub-module `ncl_req_sync`: a parameterized SYNC-deep reset-to-0 synchronizer, reused for any other async input.
- FSM, datapath registers and watchdog stay in `ncl_sink_ctrl`.

## Test plan
- Reset: hold `rst_n`=0 with `req_in`=1 → all outputs 0, and `ack_out` stays 0 until a `start` is accepted.
- Burst of 3: `burst_len`=3, bench tokenflow model sends 0, 2, 6 → three ack pulses, `ack_out` rises 3 edges after each req; `tok_cnt`=3, `last_data`=6, `xor_acc`=4, single `done` pulse, `busy`=0 afterwards.
- Abort mid-handshake: `abort` raised while in HOLD_ACK → handshake completes (ack falls after req falls), IDLE, `done` never asserted, `tok_cnt` unchanged.
- Watchdog: `start` with `req_in` held 0 for 4095 cycles → `timeout`=1, `busy`=0, `ack_out`=0; the next `start` clears `timeout`.
- Free-run wrap: `burst_len`=0, 300 tokens then `abort` → `tok_cnt`=44, no `done`; a `start` pulse during the run has no effect.
- Coincident events: `req_s` rises in the same cycle as `abort` in WAIT_REQ → token is captured and acked, then IDLE after the return phase.
